// File: rtl/runahead_pkg.sv
// Shared types and widths for the runahead controller.
package runahead_pkg;

  typedef enum logic [1:0] {
    NORMAL,
    ARMED,
    RUNAHEAD,
    EXIT
  } runahead_state_t;

  localparam int CYC_W = 16;
  localparam int CNT_W = 16;

endpackage

// File: rtl/runahead_ctrl_inv_tracker.sv
// Per-register INV bits used while running ahead of a load miss.
module inv_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic       wdata,
  input  logic       clr,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  output logic       rs_inv,
  output logic       rt_inv
);

  logic [31:0] inv_q;
  logic [31:0] inv_d;

  always_comb begin
    inv_d = inv_q;
    if (clr) begin
      inv_d = '0;
    end else if (we && waddr != 5'd0) begin
      inv_d[waddr] = wdata;
    end
    inv_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= '0;
    end else begin
      inv_q <= inv_d;
    end
  end

  // Reads see the pre-edge value; a same-cycle write is forwarded elsewhere.
  assign rs_inv = inv_q[rs_addr];
  assign rt_inv = inv_q[rt_addr];

endmodule

// File: rtl/runahead_ctrl.sv
// Runahead controller: checkpoints a missing load, runs ahead with INV
// tracking, then flushes and redirects fetch back to the load.
module runahead_ctrl
  import runahead_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int ENTRY_THRESHOLD     = 4,
  parameter int MAX_RUNAHEAD_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss_stall,
  input  logic [ADDR_WIDTH-1:0] i_miss_pc,
  input  logic                  i_miss_uses_rw,
  input  logic [4:0]            i_miss_rw_addr,
  input  logic                  i_mem_done,
  input  logic                  i_wb_uses_rw,
  input  logic [4:0]            i_wb_rw_addr,
  input  logic                  i_wb_inv,
  input  logic                  i_uses_rs,
  input  logic                  i_uses_rt,
  input  logic [4:0]            i_rs_addr,
  input  logic [4:0]            i_rt_addr,
  output logic                  runahead_mode,
  output logic                  runahead_done,
  output logic                  o_load_inv_retire,
  output logic                  o_flush,
  output logic                  o_redirect_valid,
  output logic [ADDR_WIDTH-1:0] o_redirect_pc,
  output logic                  o_rs_inv,
  output logic                  o_rt_inv,
  output logic [15:0]           o_runahead_count
);

  localparam logic [CYC_W-1:0] ENTRY_LAST = CYC_W'(ENTRY_THRESHOLD - 1);
  localparam logic [CYC_W-1:0] TO_LAST    = CYC_W'(MAX_RUNAHEAD_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  runahead_state_t state_q, state_d;
  logic [CYC_W-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic [ADDR_WIDTH-1:0] chk_pc_q, chk_pc_d;
  logic                  chk_uses_q, chk_uses_d;
  logic [4:0]            chk_rw_q, chk_rw_d;
  logic [CNT_W-1:0]      ra_cnt_q, ra_cnt_d;

  logic       enter;
  logic       inv_we;
  logic [4:0] inv_waddr;
  logic       inv_wdata;
  logic       inv_clr;
  logic       rs_inv_raw;
  logic       rt_inv_raw;

  always_comb begin
    state_d    = state_q;
    cyc_cnt_d  = cyc_cnt_q;
    chk_pc_d   = chk_pc_q;
    chk_uses_d = chk_uses_q;
    chk_rw_d   = chk_rw_q;
    ra_cnt_d   = ra_cnt_q;
    enter      = 1'b0;
    inv_we     = 1'b0;
    inv_waddr  = i_wb_rw_addr;
    inv_wdata  = i_wb_inv;
    inv_clr    = 1'b0;

    unique case (state_q)
      NORMAL: begin
        cyc_cnt_d = '0;
        if (i_miss_stall) begin
          chk_pc_d   = i_miss_pc;
          chk_uses_d = i_miss_uses_rw;
          chk_rw_d   = i_miss_rw_addr;
          if (ENTRY_THRESHOLD == 1) begin
            enter = 1'b1;
          end else begin
            state_d   = ARMED;
            cyc_cnt_d = CYC_ONE;
          end
        end
      end
      ARMED: begin
        if (!i_miss_stall || i_mem_done) begin
          state_d   = NORMAL;
          cyc_cnt_d = '0;
        end else if (cyc_cnt_q == ENTRY_LAST) begin
          enter = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_ONE;
        end
      end
      RUNAHEAD: begin
        inv_we    = i_wb_uses_rw;
        cyc_cnt_d = cyc_cnt_q + CYC_ONE;
        if (i_mem_done || cyc_cnt_q == TO_LAST) begin
          state_d   = EXIT;
          cyc_cnt_d = '0;
        end
      end
      EXIT: begin
        inv_clr = 1'b1;
        state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase

    // Entry poisons the load's destination using the checkpoint being taken.
    if (enter) begin
      state_d   = RUNAHEAD;
      cyc_cnt_d = '0;
      inv_we    = chk_uses_d;
      inv_waddr = chk_rw_d;
      inv_wdata = 1'b1;
      if (ra_cnt_q != '1) begin
        ra_cnt_d = ra_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NORMAL;
      cyc_cnt_q  <= '0;
      chk_pc_q   <= '0;
      chk_uses_q <= 1'b0;
      chk_rw_q   <= '0;
      ra_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      chk_pc_q   <= chk_pc_d;
      chk_uses_q <= chk_uses_d;
      chk_rw_q   <= chk_rw_d;
      ra_cnt_q   <= ra_cnt_d;
    end
  end

  inv_tracker u_inv (
    .clk     (clk),
    .rst     (rst),
    .we      (inv_we),
    .waddr   (inv_waddr),
    .wdata   (inv_wdata),
    .clr     (inv_clr),
    .rs_addr (i_rs_addr),
    .rt_addr (i_rt_addr),
    .rs_inv  (rs_inv_raw),
    .rt_inv  (rt_inv_raw)
  );

  assign runahead_mode     = (state_q == RUNAHEAD);
  assign runahead_done     = (state_q == EXIT);
  assign o_flush           = (state_q == EXIT);
  assign o_redirect_valid  = (state_q == EXIT);
  assign o_redirect_pc     = (state_q == EXIT) ? chk_pc_q : '0;
  assign o_load_inv_retire = enter;
  assign o_rs_inv          = runahead_mode & i_uses_rs & rs_inv_raw;
  assign o_rt_inv          = runahead_mode & i_uses_rt & rt_inv_raw;
  assign o_runahead_count  = ra_cnt_q;

endmodule

// File: tb/tb_runahead_ctrl.sv
// Directed vector bench for runahead_ctrl (threshold 4, timeout 8).
module tb_runahead_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss_stall = 1'b0;
  logic [31:0] i_miss_pc = '0;
  logic        i_miss_uses_rw = 1'b0;
  logic [4:0]  i_miss_rw_addr = '0;
  logic        i_mem_done = 1'b0;
  logic        i_wb_uses_rw = 1'b0;
  logic [4:0]  i_wb_rw_addr = '0;
  logic        i_wb_inv = 1'b0;
  logic        i_uses_rs = 1'b0;
  logic        i_uses_rt = 1'b0;
  logic [4:0]  i_rs_addr = '0;
  logic [4:0]  i_rt_addr = '0;
  logic        runahead_mode;
  logic        runahead_done;
  logic        o_load_inv_retire;
  logic        o_flush;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_rs_inv;
  logic        o_rt_inv;
  logic [15:0] o_runahead_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  runahead_ctrl #(
    .ADDR_WIDTH          (32),
    .ENTRY_THRESHOLD     (4),
    .MAX_RUNAHEAD_CYCLES (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_miss_stall      (i_miss_stall),
    .i_miss_pc         (i_miss_pc),
    .i_miss_uses_rw    (i_miss_uses_rw),
    .i_miss_rw_addr    (i_miss_rw_addr),
    .i_mem_done        (i_mem_done),
    .i_wb_uses_rw      (i_wb_uses_rw),
    .i_wb_rw_addr      (i_wb_rw_addr),
    .i_wb_inv          (i_wb_inv),
    .i_uses_rs         (i_uses_rs),
    .i_uses_rt         (i_uses_rt),
    .i_rs_addr         (i_rs_addr),
    .i_rt_addr         (i_rt_addr),
    .runahead_mode     (runahead_mode),
    .runahead_done     (runahead_done),
    .o_load_inv_retire (o_load_inv_retire),
    .o_flush           (o_flush),
    .o_redirect_valid  (o_redirect_valid),
    .o_redirect_pc     (o_redirect_pc),
    .o_rs_inv          (o_rs_inv),
    .o_rt_inv          (o_rt_inv),
    .o_runahead_count  (o_runahead_count)
  );

  // flags = {mode, done, retire, flush, redirect_valid}
  localparam logic [4:0] F0 = 5'b00000;
  localparam logic [4:0] FM = 5'b10000;
  localparam logic [4:0] FR = 5'b00100;
  localparam logic [4:0] FD = 5'b01011;

  typedef struct packed {
    logic        stall;
    logic [31:0] pc;
    logic        uses_rw;
    logic [4:0]  rw;
    logic        mdone;
    logic        wbu;
    logic [4:0]  wba;
    logic        wbi;
    logic        urs;
    logic [4:0]  rs;
    logic        urt;
    logic [4:0]  rt;
    logic [4:0]  flags;
    logic [31:0] rpc;
    logic        rsi;
    logic        rti;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t cv = '0;

  task automatic mi(input logic [31:0] p, input logic u,
                    input logic [4:0] r);
    cv.stall = 1'b1; cv.pc = p; cv.uses_rw = u; cv.rw = r;
  endtask

  task automatic md();
    cv.mdone = 1'b1;
  endtask

  task automatic wb(input logic [4:0] a, input logic i);
    cv.wbu = 1'b1; cv.wba = a; cv.wbi = i;
  endtask

  task automatic rd(input logic urs, input logic [4:0] rs,
                    input logic urt, input logic [4:0] rt);
    cv.urs = urs; cv.rs = rs; cv.urt = urt; cv.rt = rt;
  endtask

  task automatic ex(input logic [4:0] f, input logic [31:0] rpc,
                    input logic rsi, input logic rti,
                    input logic [15:0] c);
    cv.flags = f; cv.rpc = rpc; cv.rsi = rsi; cv.rti = rti; cv.cnt = c;
    tbl.push_back(cv);
    cv = '0;
  endtask

  task automatic drive(input vec_t v);
    i_miss_stall   = v.stall;
    i_miss_pc      = v.pc;
    i_miss_uses_rw = v.uses_rw;
    i_miss_rw_addr = v.rw;
    i_mem_done     = v.mdone;
    i_wb_uses_rw   = v.wbu;
    i_wb_rw_addr   = v.wba;
    i_wb_inv       = v.wbi;
    i_uses_rs      = v.urs;
    i_rs_addr      = v.rs;
    i_uses_rt      = v.urt;
    i_rt_addr      = v.rt;
  endtask

  task automatic chk(input string nm, input logic [4:0] ef,
                     input logic [31:0] erpc, input logic ersi,
                     input logic erti, input logic [15:0] ecnt);
    logic [54:0] got;
    logic [54:0] exp;
    got = {runahead_mode, runahead_done, o_load_inv_retire, o_flush,
           o_redirect_valid, o_redirect_pc, o_rs_inv, o_rt_inv,
           o_runahead_count};
    exp = {ef, erpc, ersi, erti, ecnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got flags=%b pc=%h rs=%b rt=%b cnt=%0d exp flags=%b pc=%h rs=%b rt=%b cnt=%0d",
               nm, got[54:50], got[49:18], got[17], got[16], got[15:0],
               ef, erpc, ersi, erti, ecnt);
    end
  endtask

  task automatic build();
    // short miss, then mem_done exactly at the threshold cycle
    mi('h100, 1, 5); ex(F0, 0, 0, 0, 0);
    mi('h100, 1, 5); ex(F0, 0, 0, 0, 0);
    md();            ex(F0, 0, 0, 0, 0);
    ex(F0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      mi('h200, 1, 6); ex(F0, 0, 0, 0, 0);
    end
    mi('h200, 1, 6); md(); ex(F0, 0, 0, 0, 0);
    ex(F0, 0, 0, 0, 0);
    md(); ex(F0, 0, 0, 0, 0);
    ex(F0, 0, 0, 0, 0);
    // entry at 0x400/r8, INV propagation, exit on mem_done
    mi('h400, 1, 8); ex(F0, 0, 0, 0, 0);
    mi('h404, 1, 9); ex(F0, 0, 0, 0, 0);
    mi('h404, 1, 9); ex(F0, 0, 0, 0, 0);
    mi('h404, 1, 9); rd(1, 8, 0, 0); ex(FR, 0, 0, 0, 0);
    rd(1, 8, 1, 9); wb(9, 1); ex(FM, 0, 1, 0, 1);
    rd(1, 9, 1, 8); wb(9, 0); ex(FM, 0, 1, 1, 1);
    rd(1, 9, 1, 0); wb(0, 1); ex(FM, 0, 0, 0, 1);
    mi('h800, 1, 3); rd(1, 0, 0, 8); md(); ex(FM, 0, 0, 0, 1);
    rd(1, 8, 1, 8); ex(FD, 'h400, 0, 0, 1);
    rd(1, 8, 1, 9); ex(F0, 0, 0, 0, 1);
    // timeout with no mem_done; load without a destination
    for (int k = 0; k < 3; k++) begin
      mi('h500, 0, 8); ex(F0, 0, 0, 0, 1);
    end
    mi('h500, 0, 8); ex(FR, 0, 0, 0, 1);
    rd(1, 8, 1, 9); ex(FM, 0, 0, 0, 2);
    for (int k = 1; k < 8; k++) begin
      ex(FM, 0, 0, 0, 2);
    end
    ex(FD, 'h500, 0, 0, 2);
    ex(F0, 0, 0, 0, 2);
    // mem_done coincident with the timeout cycle
    for (int k = 0; k < 3; k++) begin
      mi('h600, 1, 0); ex(F0, 0, 0, 0, 2);
    end
    mi('h600, 1, 0); ex(FR, 0, 0, 0, 2);
    rd(1, 0, 1, 0); ex(FM, 0, 0, 0, 3);
    for (int k = 1; k < 7; k++) begin
      ex(FM, 0, 0, 0, 3);
    end
    md(); ex(FM, 0, 0, 0, 3);
    ex(FD, 'h600, 0, 0, 3);
    ex(F0, 0, 0, 0, 3);
    ex(F0, 0, 0, 0, 3);
  endtask

  initial begin
    vec_t idle;
    bit   seen;
    idle = '0;
    build();
    @(negedge clk);
    chk("reset_state", F0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), tbl[i].flags, tbl[i].rpc,
          tbl[i].rsi, tbl[i].rti, tbl[i].cnt);
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of runahead
    cv = '0;
    mi('h700, 1, 4);
    rd(1, 4, 0, 0);
    drive(cv);
    cv = '0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (runahead_mode) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL enter_timeout got mode=0 exp mode=1");
    end
    i_miss_stall = 1'b0;
    @(posedge clk); #3;
    chk("pre_reset", FM, 0, 1, 0, 4);
    rst = 1'b1;
    #1;
    chk("async_reset", F0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("in_reset%0d", k), F0, 0, 0, 0, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(idle);
    i_uses_rs = 1'b1;
    i_rs_addr = 5'd4;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", k), F0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
